mips_mem_responder: RTL

- Memory-side responder for the multi-cycle MIPS core's unified instruction/data bus.
- Services the core's MemRead/MemWrite requests against an internal word-addressed RAM with parameterized read/write latency.
- Drives Memory_out back to the core and raises a one-cycle mem_ready on completion.
- Flags illegal requests on mem_err.

---
 rtl/mips_mem_responder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// mips_mem_responder
// Memory-side responder for the multi-cycle MIPS core's unified bus.
// Services MemRead/MemWrite requests against an internal word-addressed RAM
// with configurable read and write latency, returns read data on Memory_out
// and signals completion with a one-cycle mem_ready pulse. Requests that are
// malformed (read and write together, misaligned, or out of range) are
// rejected with a one-cycle mem_err pulse and perform no access.
//
// Parameters:
//   ADDR_BITS  word-address width, RAM depth = 2**ADDR_BITS words
//   READ_LAT   clock edges from read capture to data valid (1..15)
//   WRITE_LAT  clock edges from write capture to commit (1..15)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   MemRead     read request level
//   MemWrite    write request level
//   Adr         byte address, word index = Adr[ADDR_BITS+1:2]
//   B_out       write data
//   Memory_out  registered read data, holds last completed read
//   mem_ready   one-cycle pulse: access completed
//   mem_err     one-cycle pulse: request rejected
module mips_mem_responder #(
   parameter int ADDR_BITS = 10,
   parameter int READ_LAT  = 1,
   parameter int WRITE_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] B_out,
   output logic [31:0] Memory_out,
   output logic        mem_ready,
   output logic        mem_err
);

   localparam int DEPTH = 1 << ADDR_BITS;
   localparam logic [3:0] RD_CNT = 4'(READ_LAT - 1);
   localparam logic [3:0] WR_CNT = 4'(WRITE_LAT - 1);

   typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

   state_t               state, state_next;
   logic [3:0]           cnt, cnt_next;
   logic [ADDR_BITS-1:0] idx, idx_next;
   logic [31:0]          wdata, wdata_next;
   logic                 ready_next, err_next;
   logic                 rd_done, wr_done;
   logic                 bad_align, bad_range;

   logic [31:0] ram [DEPTH];

   assign bad_align = (Adr[1:0] != 2'b00);
   // Any byte-address bit above the RAM window set means out of range.
   assign bad_range = ((Adr >> (ADDR_BITS + 2)) != 32'd0);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      wdata_next = wdata;
      ready_next = 1'b0;
      err_next   = 1'b0;
      rd_done    = 1'b0;
      wr_done    = 1'b0;
      case (state)
         IDLE: begin
            if (MemRead && MemWrite) begin
               err_next = 1'b1;
            end else if ((MemRead || MemWrite) && (bad_align || bad_range)) begin
               err_next = 1'b1;
            end else if (MemRead) begin
               idx_next   = Adr[ADDR_BITS+1:2];
               cnt_next   = RD_CNT;
               state_next = RD_BUSY;
            end else if (MemWrite) begin
               idx_next   = Adr[ADDR_BITS+1:2];
               wdata_next = B_out;
               cnt_next   = WR_CNT;
               state_next = WR_BUSY;
            end
         end
         RD_BUSY: begin
            if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               rd_done    = 1'b1;
               ready_next = 1'b1;
               state_next = IDLE;
            end
         end
         WR_BUSY: begin
            if (cnt != 4'd0) begin
               cnt_next = cnt - 4'd1;
            end else begin
               wr_done    = 1'b1;
               ready_next = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         idx        <= '0;
         wdata      <= 32'd0;
         mem_ready  <= 1'b0;
         mem_err    <= 1'b0;
         Memory_out <= 32'd0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         idx       <= idx_next;
         wdata     <= wdata_next;
         mem_ready <= ready_next;
         mem_err   <= err_next;
         if (rd_done) begin
            Memory_out <= ram[idx];
         end
      end
   end

   // RAM is never cleared. A reset forces state to IDLE, so wr_done is low
   // at any edge during reset and an interrupted write is never committed.
   always_ff @(posedge clk) begin
      if (wr_done) begin
         ram[idx] <= wdata;
      end
   end

endmodule
